vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
`default_nettype none
// vga_sync_rx: recovers pixel position and timing lock from VGA hSync/vSync.
// Optional 16-bit locked-frame counter output when VGA_RX_FRAME_COUNT_EN is defined.
module vga_sync_rx #(
   parameter int H_ACT_START = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACT_START = 35,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2,
   parameter int H_TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hSync,
   input  logic        vSync,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        active,
   output logic        locked,
   output logic [10:0] lineLen,
   output logic [10:0] frameLines,
   output logic        syncErr
`ifdef VGA_RX_FRAME_COUNT_EN
   ,
   output logic [15:0] frameCount
`endif
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [10:0] CNT_MAX  = 11'h7FF;
   localparam logic [10:0] H_LO     = 11'(H_ACT_START);
   localparam logic [10:0] H_HI     = 11'(H_ACT_START + H_ACTIVE);
   localparam logic [10:0] V_LO     = 11'(V_ACT_START);
   localparam logic [10:0] V_HI     = 11'(V_ACT_START + V_ACTIVE);
   localparam logic [10:0] H_TO_PRE = 11'(H_TIMEOUT - 1);
   localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

   state_t      state, state_nxt;
   logic        hs_q, vs_q;
   logic [10:0] h_cnt, v_cnt;
   logic        v_pend;
   logic [10:0] h_cand;
   logic [7:0]  match_cnt, match_nxt;
   logic [10:0] len_nxt, lines_nxt;
   logic        err_nxt;
   logic [9:0]  x_hold, y_hold;

   // Edge events are seen one cycle early so counters read 0 on the first low cycle of hs_q.
   logic        hs_fall, vs_fall, timeout, line_bad, frame_ok;
   logic [10:0] h_cand_now, v_cand_now, h_cand_lat;
   logic        h_in, v_in;

   assign hs_fall    = hs_q & ~hSync;
   assign vs_fall    = vs_q & ~vSync;
   assign h_cand_now = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
   assign v_cand_now = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 11'd1;
   assign h_cand_lat = hs_fall ? h_cand_now : h_cand;
   assign timeout    = ~hs_fall && (h_cnt == H_TO_PRE);
   assign line_bad   = hs_fall && (h_cand_now != lineLen);
   assign frame_ok   = (v_cand_now == frameLines);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         h_cnt  <= '0;
         v_cnt  <= '0;
         v_pend <= 1'b0;
         h_cand <= '0;
      end else begin
         hs_q <= hSync;
         vs_q <= vSync;
         if (hs_fall) begin
            h_cnt  <= '0;
            h_cand <= h_cand_now;
         end else if (h_cnt != CNT_MAX) begin
            h_cnt <= h_cnt + 11'd1;
         end
         // vCnt restarts on the hSync fall coinciding with or first following a vSync fall.
         if (hs_fall) begin
            if (vs_fall || v_pend)
               v_cnt <= '0;
            else if (v_cnt != CNT_MAX)
               v_cnt <= v_cnt + 11'd1;
            v_pend <= 1'b0;
         end else if (vs_fall) begin
            v_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         match_cnt  <= '0;
         lineLen    <= '0;
         frameLines <= '0;
         syncErr    <= 1'b0;
         x_hold     <= '0;
         y_hold     <= '0;
      end else begin
         state      <= state_nxt;
         match_cnt  <= match_nxt;
         lineLen    <= len_nxt;
         frameLines <= lines_nxt;
         syncErr    <= err_nxt;
         x_hold     <= x;
         y_hold     <= y;
      end
   end

   // A line mismatch takes precedence over a frame check in the same cycle.
   always_comb begin
      state_nxt = state;
      match_nxt = match_cnt;
      len_nxt   = lineLen;
      lines_nxt = frameLines;
      err_nxt   = 1'b0;
      if (timeout) begin
         state_nxt = SEARCH;
         err_nxt   = (state == LOCKED);
      end else begin
         case (state)
            SEARCH: begin
               if (vs_fall) begin
                  len_nxt   = h_cand_lat;
                  lines_nxt = v_cand_now;
                  match_nxt = '0;
                  state_nxt = VERIFY;
               end
            end
            VERIFY: begin
               if (line_bad) begin
                  state_nxt = SEARCH;
               end else if (vs_fall) begin
                  if (frame_ok) begin
                     match_nxt = match_cnt + 8'd1;
                     if (match_nxt >= LOCK_N)
                        state_nxt = LOCKED;
                  end else begin
                     state_nxt = SEARCH;
                  end
               end
            end
            LOCKED: begin
               if (line_bad || (vs_fall && !frame_ok)) begin
                  state_nxt = SEARCH;
                  err_nxt   = 1'b1;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   assign locked = (state == LOCKED);
   assign h_in   = (h_cnt >= H_LO) && (h_cnt < H_HI);
   assign v_in   = (v_cnt >= V_LO) && (v_cnt < V_HI);
   assign active = locked && h_in && v_in;
   assign x      = active ? 10'(h_cnt - H_LO) : x_hold;
   assign y      = active ? 10'(v_cnt - V_LO) : y_hold;

`ifdef VGA_RX_FRAME_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         frameCount <= '0;
      else if (vs_fall && locked)
         frameCount <= frameCount + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
`default_nettype none
// tb_vga_sync_rx: full 800-clock VGA lines, frames shortened to 6 lines
// (vSync low lines 0-1, active lines 2-4) to keep the run short.
module tb_vga_sync_rx;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hSync = 1'b1;
   logic        vSync = 1'b1;
   logic [9:0]  x, y;
   logic        active, locked, syncErr;
   logic [10:0] lineLen, frameLines;
`ifdef VGA_RX_FRAME_COUNT_EN
   logic [15:0] frameCount;
`endif

   vga_sync_rx #(
      .H_ACT_START(144), .H_ACTIVE(640), .V_ACT_START(2), .V_ACTIVE(3),
      .LOCK_FRAMES(2), .H_TIMEOUT(1023)
   ) dut (
      .clk(clk), .reset_n(reset_n), .hSync(hSync), .vSync(vSync),
      .x(x), .y(y), .active(active), .locked(locked),
      .lineLen(lineLen), .frameLines(frameLines), .syncErr(syncErr)
`ifdef VGA_RX_FRAME_COUNT_EN
      , .frameCount(frameCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         line;
      int         pix;
      logic       act;
      logic [9:0] ex;
      logic [9:0] ey;
   } vec_t;

   vec_t tbl[8];
   int   total = 0;
   int   bad = 0;
   int   cur_l = 1, cur_p = 0, app_l = -1, app_p = -1;
   int   short_line = -1;
   bit   skip_v = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic h, input logic v);
      @(negedge clk);
      hSync = h;
      vSync = v;
      @(posedge clk);
      #1;
   endtask

   // Applies the next pixel of the stream; after it, hCnt equals app_p and vCnt app_l.
   task automatic px();
      int len;
      len = (cur_l == short_line) ? 799 : 800;
      tick((cur_p < 96) ? 1'b0 : 1'b1, (cur_l < 2 && !skip_v) ? 1'b0 : 1'b1);
      app_l = cur_l;
      app_p = cur_p;
      cur_p++;
      if (cur_p >= len) begin
         cur_p = 0;
         if (cur_l == short_line) short_line = -1;
         cur_l = (cur_l == 5) ? 0 : cur_l + 1;
         if (cur_l == 0) skip_v = 1'b0;
      end
   endtask

   task automatic run_to(input int l, input int p);
      int n;
      n = 0;
      do begin
         px();
         n++;
      end while (!(app_l == l && app_p == p) && n < 10000);
      if (!(app_l == l && app_p == p)) begin
         total++;
         bad++;
         $display("FAIL run_to: reached %0d/%0d expected %0d/%0d", app_l, app_p, l, p);
      end
   endtask

   initial begin
      int first_err, n_err;

      tbl[0] = '{1, 400, 1'b0, 10'd0,   10'd0};
      tbl[1] = '{2, 143, 1'b0, 10'd0,   10'd0};
      tbl[2] = '{2, 144, 1'b1, 10'd0,   10'd0};
      tbl[3] = '{2, 145, 1'b1, 10'd1,   10'd0};
      tbl[4] = '{3, 500, 1'b1, 10'd356, 10'd1};
      tbl[5] = '{4, 783, 1'b1, 10'd639, 10'd2};
      tbl[6] = '{4, 784, 1'b0, 10'd639, 10'd2};
      tbl[7] = '{5, 144, 1'b0, 10'd639, 10'd2};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_syncErr", int'(syncErr), 0);
      chk("rst_lineLen", int'(lineLen), 0);
      chk("rst_frameLines", int'(frameLines), 0);
      chk("rst_xy", int'({x, y}), 0);
      reset_n = 1'b1;
      repeat (5) tick(1'b1, 1'b1);

      // Partial first frame starts at line 1 with vSync idle; first vSync fall at 0/0.
      run_to(0, 0);
      chk("fall1_locked", int'(locked), 0);
      chk("fall1_lineLen", int'(lineLen), 800);
      chk("fall1_frameLines", int'(frameLines), 6);
      run_to(0, 0);
      chk("fall2_locked", int'(locked), 0);
      run_to(5, 799);
      chk("pre_fall3_locked", int'(locked), 0);
      run_to(0, 0);
      chk("fall3_locked", int'(locked), 1);
      chk("fall3_syncErr", int'(syncErr), 0);

      for (int i = 0; i < 8; i++) begin
         run_to(tbl[i].line, tbl[i].pix);
         chk($sformatf("tbl%0d_lock_act_x_y", i), int'({locked, active, x, y}),
             int'({1'b1, tbl[i].act, tbl[i].ex, tbl[i].ey}));
      end

`ifdef VGA_RX_FRAME_COUNT_EN
      force dut.frameCount = 16'hFFFF;
      #1;
      release dut.frameCount;
`endif
      run_to(0, 0);
      chk("fall4_locked", int'(locked), 1);
`ifdef VGA_RX_FRAME_COUNT_EN
      chk("frameCount_wrap", int'(frameCount), 0);
`endif

      short_line = 3;
      run_to(4, 0);
      chk("short_syncErr", int'(syncErr), 1);
      chk("short_locked", int'(locked), 0);
      run_to(4, 1);
      chk("short_syncErr_1cyc", int'(syncErr), 0);
      run_to(0, 0);
      chk("relockA_locked", int'(locked), 0);
      run_to(0, 0);
      chk("relockB_locked", int'(locked), 0);
      run_to(0, 0);
      chk("relockC_locked", int'(locked), 1);
      chk("relock_lens", int'({lineLen, frameLines}), int'({11'd800, 11'd6}));

      // hSync stuck high from line 2: hCnt passes 799+k, timeout at k=224.
      run_to(1, 799);
      first_err = -1;
      n_err = 0;
      for (int k = 1; k <= 1100; k++) begin
         tick(1'b1, 1'b1);
         if (syncErr) begin
            n_err++;
            if (first_err < 0) first_err = k;
         end
      end
      chk("timeout_at", first_err, 224);
      chk("timeout_pulses", n_err, 1);
      chk("timeout_locked", int'(locked), 0);

      cur_l = 2;
      cur_p = 0;
      run_to(0, 0);
      run_to(0, 0);
      chk("resume_fall2_locked", int'(locked), 0);
      run_to(0, 0);
      chk("resume_fall3_locked", int'(locked), 1);
      run_to(3, 300);
      chk("pre_rst_act_x_y", int'({active, x, y}), int'({1'b1, 10'd156, 10'd1}));

      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_flags", int'({locked, active, syncErr}), 0);
      chk("async_rst_xy", int'({x, y}), 0);
      chk("async_rst_lens", int'({lineLen, frameLines}), 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) tick(1'b1, 1'b1);
      chk("post_rst_locked", int'(locked), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
